pwm_cfg_sequencer: RTL and testbench
====================================

// Module: pwm_cfg_sequencer
// PURPOSE
//  Configuration controller between the SPI register-write path and pwm_peripheral.
//  Accepts single-byte register writes and applies output enables immediately.
//  Holds PWM enables and duty cycle in shadow registers and commits them atomically
//  at a PWM period boundary, so no period is ever emitted with a half-updated configuration.
//  A timeout forces the commit when the PWM is idle and produces no boundaries.
// PARAMETERS
//  TIMEOUT_CYCLES  65535  clk cycles in PENDING before a forced commit (1..65535)
//  RAMP_STEP       1      duty-cycle step per period; used only when DUTY_RAMP_EN is defined
// PORTS
//  clk              in   1  system clock
//  rst_n            in   1  asynchronous active-low reset
//  wr_valid         in   1  write request
//  wr_ready         out  1  write accepted in any cycle where wr_valid & wr_ready are both 1
//  wr_addr          in   7  register address
//  wr_data          in   8  register data
//  period_end       in   1  one-cycle strobe from the PWM on its last counter cycle
//  en_reg_out_7_0   out  8  live output-enable register, address 0x00
//  en_reg_out_15_8  out  8  live output-enable register, address 0x01
//  en_reg_pwm_7_0   out  8  live PWM-enable register, address 0x02 (shadowed)
//  en_reg_pwm_15_8  out  8  live PWM-enable register, address 0x03 (shadowed)
//  pwm_duty_cycle   out  8  live duty cycle, address 0x04 (shadowed)
//  pending          out  1  shadow holds uncommitted data
//  commit_pulse     out  1  one-cycle pulse in the cycle the live registers update
//  addr_err         out  1  one-cycle pulse on an accepted write to address >= 0x05
// BEHAVIOUR
//  Reset:
//   - all registers and shadows are 0x00; pending=0, commit_pulse=0, addr_err=0
//   - wr_ready=1; state=IDLE; timeout counter=0
//   - reset mid-operation discards the shadow contents and any pending commit
//  Writes:
//   - 0x00/0x01: the live register updates on the clock edge that accepts the write
//     (latency 1), in every state
//   - 0x02..0x04: the write updates the shadow copy only
//   - 0x05..0x7F: no register changes; addr_err pulses on the next cycle
//   - repeated writes to the same shadow address: the last one wins
//  FSM:
//   - IDLE: an accepted shadow write moves to PENDING. A period_end in that same
//     cycle is ignored, so the commit waits for the next boundary.
//   - PENDING: pending=1 and the counter increments each cycle. Shadow writes are
//     still accepted. On period_end, or when the counter reaches TIMEOUT_CYCLES-1,
//     move to COMMIT. A write accepted in that same cycle is included in the commit.
//   - COMMIT (exactly 1 cycle):
//     - wr_ready=0
//     - the three shadows are copied to the live registers
//     - commit_pulse=1
//     - the counter clears; go to IDLE
//  Update ordering: in the cycle after COMMIT, all three live shadowed registers
//   show the new values together. Output-enable writes are never delayed.
//  Width: the timeout counter is 16 bits and saturates; it never wraps.
// CONFIGURATION
//  DUTY_RAMP_EN undefined:
//   - pwm_duty_cycle jumps to the shadow value at COMMIT
//  DUTY_RAMP_EN defined:
//   - COMMIT loads an internal duty_target; the enables still update at COMMIT
//   - on each period_end, pwm_duty_cycle moves toward duty_target by
//     min(RAMP_STEP, |target-duty|), never overshooting and never wrapping past 0x00/0xFF
//   - pending stays 1 until pwm_duty_cycle equals duty_target
//   - the FSM is otherwise unchanged
// TESTING
//  1. Reset, then write 0x00=0xA5 -> en_reg_out_7_0=0xA5 one cycle later; pending stays 0.
//  2. Write 0x04=0x80 with no period_end -> pwm_duty_cycle stays 0x00 and pending=1.
//     Then a period_end strobe -> COMMIT with wr_ready=0, commit_pulse, duty=0x80 the next cycle.
//  3. Write 0x02=0x0F, 0x03=0xF0 and 0x04=0x40 across different cycles, then period_end
//     -> all three registers change in the same cycle and commit_pulse fires exactly once.
//  4. TIMEOUT_CYCLES=16: write 0x04=0x10 with no period_end -> commit occurs 16 cycles
//     after entering PENDING; duty=0x10.
//  5. A write to 0x04=0x22 in the same cycle as period_end while PENDING -> committed duty=0x22.
//     A write to 0x07 -> addr_err pulse and no register change.
//     Assert rst_n while PENDING -> all outputs return to 0, and no commit follows.
//  6. DUTY_RAMP_EN defined, RAMP_STEP=4, duty=0x00, commit target 0x0A
//     -> successive period_ends give 0x04, 0x08, 0x0A; pending clears at 0x0A.

Source files
------------

// File: rtl/pwm_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_cfg_sequencer
//
// Sits between the SPI register-write path and pwm_peripheral. It takes
// single-byte register writes and splits them into two groups:
//   - output enables (0x00, 0x01) are applied on the accepting clock edge;
//   - PWM enables (0x02, 0x03) and duty cycle (0x04) go to shadow registers.
//     The shadow registers are copied to the live registers together, at a
//     PWM period boundary. A PWM period therefore never runs with a
//     half-updated configuration.
// If the PWM is idle and produces no boundary, a timeout forces the commit.
//
// Optional feature, selected with the macro DUTY_RAMP_EN:
//   - undefined: pwm_duty_cycle jumps straight to the committed value.
//   - defined:   pwm_duty_cycle moves toward the committed target on each
//                period_end, by at most RAMP_STEP per period.
//
// Parameters
//   TIMEOUT_CYCLES  cycles spent in PENDING before a forced commit (1..65535)
//   RAMP_STEP       duty step per period, ramp build only (1..255)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_valid/ready    write handshake; the write is taken when both are 1
//   wr_addr, wr_data  7-bit register address, 8-bit data
//   period_end        one-cycle strobe on the last PWM counter cycle
//   en_reg_out_*      live output-enable registers (0x00, 0x01)
//   en_reg_pwm_*      live PWM-enable registers (0x02, 0x03, shadowed)
//   pwm_duty_cycle    live duty cycle (0x04, shadowed)
//   pending           shadow holds data that is not yet live
//   commit_pulse      high in the COMMIT cycle; live registers change at its end
//   addr_err          one-cycle pulse after an accepted write to 0x05..0x7F
// ---------------------------------------------------------------------------
module pwm_cfg_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned RAMP_STEP      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       period_end,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       pending,
  output logic       commit_pulse,
  output logic       addr_err
);

  // Parameter sanity checks, done at elaboration.
  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("pwm_cfg_sequencer: TIMEOUT_CYCLES must be 1..65535");
  end
  if (RAMP_STEP == 0 || RAMP_STEP > 255) begin : g_bad_step
    $error("pwm_cfg_sequencer: RAMP_STEP must be 1..255");
  end

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  localparam logic [6:0] A_OUT_LO = 7'h00;
  localparam logic [6:0] A_OUT_HI = 7'h01;
  localparam logic [6:0] A_PWM_LO = 7'h02;
  localparam logic [6:0] A_PWM_HI = 7'h03;
  localparam logic [6:0] A_DUTY   = 7'h04;

  // One shadowed configuration set; the same shape holds the live copy.
  typedef struct packed {
    logic [7:0] en_pwm_lo;
    logic [7:0] en_pwm_hi;
    logic [7:0] duty;
  } cfg_t;

  logic [1:0]  state, state_nxt;
  logic [15:0] to_cnt;
  cfg_t        shadow, live;
  logic [7:0]  en_out_lo, en_out_hi;

  logic accept, shadow_wr, bad_addr, commit_go;

  // -------------------------------------------------------------------------
  // Write decode
  // -------------------------------------------------------------------------
  assign accept    = wr_valid & wr_ready;
  assign shadow_wr = accept && (wr_addr >= A_PWM_LO) && (wr_addr <= A_DUTY);
  assign bad_addr  = wr_addr > A_DUTY;

  // The timeout compare uses the count before this cycle's increment.
  // The first PENDING cycle sees 0, so the commit lands exactly
  // TIMEOUT_CYCLES cycles after PENDING is entered.
  assign commit_go = period_end || (to_cnt == TO_LAST);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      // A period_end that arrives together with the first shadow write is
      // deliberately ignored. The commit waits for the next full boundary.
      ST_IDLE:    if (shadow_wr) state_nxt = ST_PENDING;
      ST_PENDING: if (commit_go) state_nxt = ST_COMMIT;
      ST_COMMIT:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // wr_ready and commit_pulse come from flops driven by the next state.
  // This keeps them glitch-free for the SPI side and for the PWM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ready     <= 1'b1;
      commit_pulse <= 1'b0;
    end else begin
      wr_ready     <= (state_nxt != ST_COMMIT);
      commit_pulse <= (state_nxt == ST_COMMIT);
    end
  end

  // Timeout counter. It runs only in PENDING, saturates and never wraps,
  // and is cleared in every other state (COMMIT included).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == ST_PENDING) begin
      if (to_cnt != CNT_MAX) to_cnt <= to_cnt + 16'd1;
    end else begin
      to_cnt <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Output-enable registers: never delayed, written in any state that
  // accepts a write.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out_lo <= '0;
      en_out_hi <= '0;
    end else if (accept) begin
      if (wr_addr == A_OUT_LO) en_out_lo <= wr_data;
      if (wr_addr == A_OUT_HI) en_out_hi <= wr_data;
    end
  end

  // -------------------------------------------------------------------------
  // Shadow registers. If several writes hit the same address, the last one
  // wins. A write taken in the cycle that moves PENDING to COMMIT is already
  // in the shadow when COMMIT copies it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (accept) begin
      if (wr_addr == A_PWM_LO) shadow.en_pwm_lo <= wr_data;
      if (wr_addr == A_PWM_HI) shadow.en_pwm_hi <= wr_data;
      if (wr_addr == A_DUTY)   shadow.duty      <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_err <= 1'b0;
    else        addr_err <= accept && bad_addr;
  end

  // -------------------------------------------------------------------------
  // Live shadowed registers
  // -------------------------------------------------------------------------
`ifdef DUTY_RAMP_EN
  localparam logic [7:0] STEP = 8'(RAMP_STEP);

  logic [7:0] duty_target;
  logic [7:0] ramp_gap, ramp_inc;
  logic       ramp_up;

  // Step size is min(STEP, distance to target). The duty therefore never
  // overshoots the target and never wraps past 0x00 or 0xFF.
  always_comb begin
    ramp_up  = duty_target > live.duty;
    ramp_gap = ramp_up ? (duty_target - live.duty) : (live.duty - duty_target);
    ramp_inc = (ramp_gap < STEP) ? ramp_gap : STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live        <= '0;
      duty_target <= '0;
    end else begin
      if (state == ST_COMMIT) begin
        live.en_pwm_lo <= shadow.en_pwm_lo;
        live.en_pwm_hi <= shadow.en_pwm_hi;
        duty_target    <= shadow.duty;
      end
      // The ramp follows the target that is in force now. A target loaded
      // in this same cycle takes effect from the next boundary onward.
      if (period_end && (ramp_gap != 8'd0)) begin
        live.duty <= ramp_up ? (live.duty + ramp_inc) : (live.duty - ramp_inc);
      end
    end
  end

  // pending stays high while the duty cycle is still ramping toward its target.
  assign pending = (state != ST_IDLE) || (live.duty != duty_target);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  live <= '0;
    else if (state == ST_COMMIT) live <= shadow;
  end

  // The shadow is still uncommitted during the COMMIT cycle itself.
  assign pending = (state != ST_IDLE);
`endif

  assign en_reg_out_7_0  = en_out_lo;
  assign en_reg_out_15_8 = en_out_hi;
  assign en_reg_pwm_7_0  = live.en_pwm_lo;
  assign en_reg_pwm_15_8 = live.en_pwm_hi;
  assign pwm_duty_cycle  = live.duty;

endmodule

// File: tb/tb_pwm_cfg_sequencer.sv
// Testbench for pwm_cfg_sequencer.
// Stimulus pushes the expected result of each commit into a queue. A monitor
// process pops that entry on every commit_pulse and checks the live
// registers in the following cycle.
module tb_pwm_cfg_sequencer;
  localparam int TO   = 16;
  localparam int STEP = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       wr_valid = 1'b0, period_end = 1'b0;
  logic [6:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ready, pending, commit_pulse, addr_err;
  logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;

  pwm_cfg_sequencer #(.TIMEOUT_CYCLES(TO), .RAMP_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .period_end(period_end),
    .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi),
    .en_reg_pwm_7_0(pwm_lo), .en_reg_pwm_15_8(pwm_hi),
    .pwm_duty_cycle(duty), .pending(pending),
    .commit_pulse(commit_pulse), .addr_err(addr_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  typedef struct {
    logic [7:0] lo, hi, duty;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] d, input int c);
    exp_t e;
    e.lo = lo; e.hi = hi; e.duty = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Monitor: runs on every commit.
  initial forever begin
    @(negedge clk);
    if (rst_n && commit_pulse === 1'b1) begin
      chk("commit_wr_ready", {31'd0, wr_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_commit actual=commit at cycle %0d expected=none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_cycle", cyc, e.cyc);
        @(negedge clk);
        chk("commit_en_pwm_lo", {24'd0, pwm_lo}, {24'd0, e.lo});
        chk("commit_en_pwm_hi", {24'd0, pwm_hi}, {24'd0, e.hi});
`ifndef DUTY_RAMP_EN
        chk("commit_duty", {24'd0, duty}, {24'd0, e.duty});
`endif
        chk("commit_pulse_single", {31'd0, commit_pulse}, 32'd0);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d, input logic pe = 1'b0);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; period_end = pe;
    step(1);
    wr_valid = 1'b0; period_end = 1'b0;
  endtask

  task automatic pulse_pe;
    period_end = 1'b1;
    step(1);
    period_end = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_lo"},  {24'd0, out_lo}, 32'd0);
    chk({tag, "_out_hi"},  {24'd0, out_hi}, 32'd0);
    chk({tag, "_pwm_lo"},  {24'd0, pwm_lo}, 32'd0);
    chk({tag, "_pwm_hi"},  {24'd0, pwm_hi}, 32'd0);
    chk({tag, "_duty"},    {24'd0, duty},   32'd0);
    chk({tag, "_pending"}, {31'd0, pending}, 32'd0);
    chk({tag, "_commit"},  {31'd0, commit_pulse}, 32'd0);
    chk({tag, "_addr_err"},{31'd0, addr_err}, 32'd0);
    chk({tag, "_wr_ready"},{31'd0, wr_ready}, 32'd1);
  endtask

  initial begin
    // Reset state.
    rst_n = 1'b0;
    step(2);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(1);

    // Output enable: visible one cycle after the accepting edge, no pending.
    wr(7'h00, 8'hA5);
    @(negedge clk);
    chk("out_lo_write", {24'd0, out_lo}, 32'hA5);
    chk("out_lo_no_pending", {31'd0, pending}, 32'd0);
    step(1);

    // Out-of-range address: addr_err pulses for one cycle, no register changes.
    wr(7'h07, 8'h99);
    @(negedge clk);
    chk("addr_err_pulse", {31'd0, addr_err}, 32'd1);
    chk("addr_err_out_lo", {24'd0, out_lo}, 32'hA5);
    chk("addr_err_out_hi", {24'd0, out_hi}, 32'd0);
    chk("addr_err_duty", {24'd0, duty}, 32'd0);
    chk("addr_err_pending", {31'd0, pending}, 32'd0);
    step(1);
    @(negedge clk);
    chk("addr_err_one_cycle", {31'd0, addr_err}, 32'd0);
    step(1);

`ifndef DUTY_RAMP_EN
    // Duty write is held in the shadow until period_end.
    wr(7'h04, 8'h80);
    @(negedge clk);
    chk("duty_held", {24'd0, duty}, 32'd0);
    chk("duty_pending", {31'd0, pending}, 32'd1);
    step(1);
    wr(7'h01, 8'h3C);              // output enable in PENDING: not delayed
    @(negedge clk);
    chk("out_hi_in_pending", {24'd0, out_hi}, 32'h3C);
    chk("duty_still_held", {24'd0, duty}, 32'd0);
    step(1);
    push(8'h00, 8'h00, 8'h80, cyc + 1);
    pulse_pe;
    step(2);
    @(negedge clk);
    chk("pending_cleared", {31'd0, pending}, 32'd0);
    step(1);

    // Three shadowed writes spread over several cycles, committed together.
    wr(7'h02, 8'h0F);
    step(1);
    wr(7'h03, 8'hF0);
    step(1);
    wr(7'h04, 8'h40);
    @(negedge clk);
    chk("multi_pwm_lo_held", {24'd0, pwm_lo}, 32'd0);
    chk("multi_duty_held", {24'd0, duty}, 32'h80);
    step(1);
    push(8'h0F, 8'hF0, 8'h40, cyc + 1);
    pulse_pe;
    step(3);

    // Timeout: no period_end; COMMIT lands TO cycles after PENDING is entered.
    push(8'h0F, 8'hF0, 8'h10, cyc + 1 + TO);
    wr(7'h04, 8'h10);
    step(TO + 4);
    @(negedge clk);
    chk("timeout_duty", {24'd0, duty}, 32'h10);
    step(1);

    // A write in the same cycle as period_end is included in the commit.
    wr(7'h04, 8'h55);
    push(8'h0F, 8'hF0, 8'h22, cyc + 1);
    wr(7'h04, 8'h22, 1'b1);
    step(3);
`else
    // Ramp: target 0x0A, step 4 -> 0x04, 0x08, 0x0A on successive boundaries.
    wr(7'h04, 8'h0A);
    @(negedge clk);
    chk("ramp_pending", {31'd0, pending}, 32'd1);
    step(1);
    push(8'h00, 8'h00, 8'h0A, cyc + 1);
    pulse_pe;
    step(1);
    @(negedge clk);
    chk("ramp_start_duty", {24'd0, duty}, 32'd0);
    chk("ramp_start_pending", {31'd0, pending}, 32'd1);
    step(1);
    begin
      logic [7:0] ramp_exp [3];
      ramp_exp[0] = 8'h04; ramp_exp[1] = 8'h08; ramp_exp[2] = 8'h0A;
      for (int i = 0; i < 3; i++) begin
        pulse_pe;
        @(negedge clk);
        chk("ramp_duty", {24'd0, duty}, {24'd0, ramp_exp[i]});
        chk("ramp_pending_step", {31'd0, pending}, (i == 2) ? 32'd0 : 32'd1);
        step(1);
      end
    end
    pulse_pe;
    @(negedge clk);
    chk("ramp_hold", {24'd0, duty}, 32'h0A);
    step(1);
`endif

    // Reset while PENDING: everything returns to 0 and the commit is lost.
    wr(7'h02, 8'hAA);
    @(negedge clk);
    chk("pre_reset_pending", {31'd0, pending}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse_pe;
      step(3);
    end
    @(negedge clk);
    chk("post_reset_pending", {31'd0, pending}, 32'd0);
    chk("post_reset_pwm_lo", {24'd0, pwm_lo}, 32'd0);
    step(1);
    // The discarded shadow value 0xAA must not reappear in the next commit.
    wr(7'h03, 8'h11);
    push(8'h00, 8'h11, 8'h00, cyc + 1);
    pulse_pe;
    step(5);

    chk("exp_queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
